mult_share_sched: RTL



---
 rtl/mult_share_sched_pkg.sv | 17 +
 rtl/acc_mult_signed.sv | 16 +
 rtl/mult_share_sched_rr_arbiter.sv | 27 ++
 rtl/mult_share_sched.sv | 103 ++++++++++
 4 files changed

// File: rtl/mult_share_sched_pkg.sv
// Shared types and helpers for the shared-multiplier scheduler.
package mult_share_sched_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int prod_w(input int w1, input int w2);
    return w1 + w2;
  endfunction

endpackage

// File: rtl/acc_mult_signed.sv
// Combinational full-precision signed multiplier with carry-in.
module acc_mult_signed #(
  parameter int W1 = 8,
  parameter int W2 = 8
) (
  input  logic [W1-1:0]    a,
  input  logic [W2-1:0]    b,
  input  logic             cin,
  output logic [W1+W2-1:0] p
);
  localparam int PW = W1 + W2;

  // Sign-extending both operands to PW keeps the low PW bits exact.
  assign p = PW'($signed(a)) * PW'($signed(b)) + PW'(cin);

endmodule

// File: rtl/mult_share_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping.
module rr_arbiter_nreq #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one signed multiplier among NREQ requesters,
// with burst lock and a registered, backpressured output stage.
module mult_share_sched
  import mult_share_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W1   = 8,
  parameter int W2   = 8,
  parameter int IDW  = clog2(NREQ),
  parameter int CNTW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ*W1-1:0]   req_a,
  input  logic [NREQ*W2-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W1+W2-1:0]     out_prod,
  output logic [IDW-1:0]       out_id,
  output logic                 busy,
  output logic [CNTW-1:0]      op_count
);
  localparam int PW = prod_w(W1, W2);

  state_t          state, nxt_state;
  logic [IDW-1:0]  lock_id, nxt_lock, rr_ptr;
  logic [NREQ-1:0] arb_gnt, sel_vec;
  logic [IDW-1:0]  arb_idx, sel_idx;
  logic            arb_any, lock_hold, adv, accept;
  logic [W1-1:0]   mul_a;
  logic [W2-1:0]   mul_b;
  logic [PW-1:0]   mul_p;

  rr_arbiter_nreq #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign adv = !out_valid || out_ready;

  // A lock owner that drops valid falls through to normal arbitration at once.
  always_comb begin
    lock_hold = (state == ST_LOCKED) && req_valid[lock_id];
    sel_vec   = lock_hold ? (NREQ'(1) << lock_id) : arb_gnt;
    sel_idx   = lock_hold ? lock_id : arb_idx;
  end

  assign req_ready = (adv && !rst) ? sel_vec : '0;
  assign accept    = |req_ready;
  assign mul_a     = req_a[sel_idx*W1 +: W1];
  assign mul_b     = req_b[sel_idx*W2 +: W2];

  acc_mult_signed #(.W1(W1), .W2(W2)) u_mult (
    .a   (mul_a),
    .b   (mul_b),
    .cin (1'b0),
    .p   (mul_p)
  );

  always_comb begin
    nxt_state = state;
    nxt_lock  = lock_id;
    if (accept) begin
      nxt_state = req_lock[sel_idx] ? ST_LOCKED : ST_IDLE;
      nxt_lock  = sel_idx;
    end else if (state == ST_LOCKED && adv && !req_valid[lock_id]) begin
      nxt_state = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lock_id   <= '0;
      rr_ptr    <= IDW'(NREQ - 1);
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_id    <= '0;
      op_count  <= '0;
    end else begin
      state   <= nxt_state;
      lock_id <= nxt_lock;
      if (out_valid && out_ready) op_count <= op_count + CNTW'(1);
      if (accept) begin
        out_valid <= 1'b1;
        out_prod  <= mul_p;
        out_id    <= sel_idx;
        rr_ptr    <= sel_idx;
      end else if (adv) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == ST_LOCKED) || out_valid;

endmodule
